button_conditioner: RTL and testbench

Parametrised multi-channel input conditioner for the combination-lock front end. It replaces the single-button synchroniser/falling-edge detector. Each of `N_CH` raw button inputs passes through a configurable synchroniser chain and a stable-count debouncer. The block then produces a registered one-cycle event pulse on rising, falling or both edges, selected at run time. Outputs feed the lock FSM directly, which never sees raw or metastable inputs.

---
 rtl/button_cond_pkg.sv | 27 ++
 rtl/button_chan.sv | 75 +++++++
 rtl/button_conditioner.sv | 61 ++++++
 tb/tb_button_conditioner.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/button_cond_pkg.sv
// Shared types and parameter limits for the multi-channel button conditioner.
package button_cond_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    localparam int unsigned MIN_SYNC_STAGES = 2;
    localparam int unsigned MIN_DB_CYCLES   = 1;

    // True when an accepted transition to new_level should produce an event.
    function automatic logic edge_match(input edge_mode_t mode, input logic new_level);
        logic hit;
        hit = 1'b0;
        case (mode)
            EDGE_RISE: hit = new_level;
            EDGE_FALL: hit = ~new_level;
            EDGE_BOTH: hit = 1'b1;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/button_chan.sv
// One conditioner channel: synchroniser chain, stable-count debouncer,
// debounced level register and one-cycle event pulse register.
module button_chan
    import button_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 4,
    parameter logic        IDLE_LEVEL  = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_button,
    input  logic [1:0] i_edge_mode,
    output logic       o_level,
    output logic       o_pulse,
    output logic       o_pulse_nxt_c
);

    localparam int unsigned    CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   r_level;
    logic                   w_level_nxt;
    logic                   r_pulse;
    logic                   w_pulse_nxt;
    logic                   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    // Synchroniser chain; stage 0 captures the raw asynchronous input.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {SYNC_STAGES{IDLE_LEVEL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_button};
        end
    end

    // Debounce decision: accept s only after DB_CYCLES consecutive differing cycles.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_pulse_nxt = 1'b0;
        if (w_s == r_level) begin
            w_cnt_nxt = '0;
        end else if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_level_nxt = w_s;
            w_pulse_nxt = edge_match(edge_mode_t'(i_edge_mode), w_s);
        end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    // Counter, level and pulse registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_level <= IDLE_LEVEL;
            r_pulse <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    assign o_level       = r_level;
    assign o_pulse       = r_pulse;
    assign o_pulse_nxt_c = w_pulse_nxt;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: N_CH independent synchronise/debounce/edge
// channels plus a registered OR of all event pulses.
module button_conditioner
    import button_cond_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 4,
    parameter logic        IDLE_LEVEL  = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] button,
    input  logic [1:0]      edge_mode,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] pulse,
    output logic            any_pulse
);

    // Elaboration-time parameter checks.
    if (N_CH < 1) begin : g_bad_nch
        $error("button_conditioner: N_CH must be at least 1");
    end
    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
        $error("button_conditioner: SYNC_STAGES below minimum");
    end
    if (DB_CYCLES < MIN_DB_CYCLES) begin : g_bad_db
        $error("button_conditioner: DB_CYCLES below minimum");
    end

    logic [N_CH-1:0] w_pulse_nxt;
    logic            r_any_pulse;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        button_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .IDLE_LEVEL  (IDLE_LEVEL)
        ) u_chan (
            .i_clk         (clk),
            .i_rst_n       (rst_n),
            .i_button      (button[g]),
            .i_edge_mode   (edge_mode),
            .o_level       (level[g]),
            .o_pulse       (pulse[g]),
            .o_pulse_nxt_c (w_pulse_nxt[g])
        );
    end

    // any_pulse is registered from the next-state pulses so it aligns with pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_any_pulse <= 1'b0;
        end else begin
            r_any_pulse <= |w_pulse_nxt;
        end
    end

    assign any_pulse = r_any_pulse;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: stimulus pushes expected events,
// a monitor pops and compares whenever the DUT shows a pulse.
module tb_button_conditioner;

    logic       clk;
    logic       rst_n;
    logic [3:0] button;
    logic [1:0] edge_mode;
    logic [3:0] level;
    logic [3:0] pulse;
    logic       any_pulse;

    typedef struct {
        logic [3:0] pulse;
        logic [3:0] level;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks;
    int   failures;
    int   cyc;

    button_conditioner #(
        .N_CH        (4),
        .SYNC_STAGES (2),
        .DB_CYCLES   (4),
        .IDLE_LEVEL  (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .button    (button),
        .edge_mode (edge_mode),
        .level     (level),
        .pulse     (pulse),
        .any_pulse (any_pulse)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive buttons on the falling edge; the next rising edge is the capture edge.
    task automatic drive(input logic [3:0] b);
        @(negedge clk);
        button = b;
    endtask

    // Event expected at the 6th rising edge after capture (capture counted as 1).
    task automatic expect_ev(input logic [3:0] p, input logic [3:0] l);
        exp_t x;
        x.pulse = p;
        x.level = l;
        x.cyc   = cyc + 6;
        sb_q.push_back(x);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: flag late/missing events, then compare any visible pulse.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (sb_q.size() != 0 && sb_q[0].cyc < cyc) begin
                mon_e = sb_q.pop_front();
                chk("missing_pulse_cycle", cyc, mon_e.cyc);
            end
            if (pulse != 4'b0 || any_pulse) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_pulse", {27'b0, pulse, any_pulse}, 32'b0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("pulse", pulse, mon_e.pulse);
                    chk("any_pulse", any_pulse, mon_e.pulse != 4'b0);
                    chk("level_at_pulse", level, mon_e.level);
                    chk("pulse_cycle", cyc, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        button    = 4'hF;
        edge_mode = 2'b00;

        // Reset state.
        wait_cyc(3);
        chk("reset_level", level, 4'hF);
        chk("reset_pulse", pulse, 4'h0);
        chk("reset_any_pulse", any_pulse, 1'b0);
        rst_n = 1'b1;
        wait_cyc(20);
        chk("idle_level", level, 4'hF);

        // FALL on ch0, then release (rising, ignored in FALL mode).
        edge_mode = 2'b10;
        drive(4'hE);
        expect_ev(4'b0001, 4'hE);
        wait_cyc(10);
        chk("fall_level", level, 4'hE);
        drive(4'hF);
        wait_cyc(10);
        chk("fall_release_level", level, 4'hF);

        // Debounce on ch1: 3-cycle glitch filtered, 4-cycle low accepted.
        drive(4'hD);
        wait_cyc(2);
        drive(4'hF);
        wait_cyc(10);
        chk("glitch_level", level, 4'hF);
        drive(4'hD);
        expect_ev(4'b0010, 4'hD);
        wait_cyc(3);
        drive(4'hF);
        wait_cyc(12);
        chk("db_return_level", level, 4'hF);

        // BOTH mode, ch3 and ch2 together.
        edge_mode = 2'b11;
        drive(4'h3);
        expect_ev(4'b1100, 4'h3);
        wait_cyc(10);
        chk("both_fall_level", level, 4'h3);
        drive(4'hF);
        expect_ev(4'b1100, 4'hF);
        wait_cyc(10);
        chk("both_rise_level", level, 4'hF);

        // OFF mode: level follows, no pulses.
        edge_mode = 2'b00;
        drive(4'h0);
        wait_cyc(10);
        chk("off_low_level", level, 4'h0);
        drive(4'hF);
        wait_cyc(10);
        chk("off_high_level", level, 4'hF);

        // RISE mode: pulse only on release of ch0.
        edge_mode = 2'b01;
        drive(4'hE);
        wait_cyc(10);
        chk("rise_press_level", level, 4'hE);
        drive(4'hF);
        expect_ev(4'b0001, 4'hF);
        wait_cyc(10);
        chk("rise_release_level", level, 4'hF);

        // Reset while ch0 counter is at 2.
        edge_mode = 2'b11;
        drive(4'hE);
        wait_cyc(4);
        rst_n  = 1'b0;
        button = 4'hF;
        #1;
        chk("midreset_level", level, 4'hF);
        chk("midreset_pulse", pulse, 4'h0);
        chk("midreset_any_pulse", any_pulse, 1'b0);
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(20);
        chk("post_reset_level", level, 4'hF);

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
